// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if
//   Bundles every non-clock/reset signal of the register-file write arbiter.
//   Signal names carry the arbiter's point of view (_i = into the arbiter,
//   _o = out of the arbiter), so the same names read correctly on both sides.
//
//   Signals
//     wb_valid_i/wb_addr_i/wb_data_i      in-order WB result (held by stall_o)
//     ll_valid_i/ll_ready_o/ll_addr_i/ll_data_i
//                                         long-latency result handshake
//     issue_valid_i/issue_addr_i          LL op issued, mark destination pending
//     rs1_addr_i/rs2_addr_i               scoreboard queries
//     rs1_busy_o/rs2_busy_o               query answers (combinational)
//     stall_o                             WB stage must hold this cycle
//     RegWrite_o/RDaddr_o/RDdata_o        registered register-file write port
//
//   Modports
//     master : pipeline side, drives requests and observes the write port
//     slave  : the arbiter itself
interface reg_write_arbiter_if;
  logic        wb_valid_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        ll_valid_i;
  logic        ll_ready_o;
  logic [4:0]  ll_addr_i;
  logic [31:0] ll_data_i;
  logic        issue_valid_i;
  logic [4:0]  issue_addr_i;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic        rs1_busy_o;
  logic        rs2_busy_o;
  logic        stall_o;
  logic        RegWrite_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;

  modport master (
    output wb_valid_i, wb_addr_i, wb_data_i,
    output ll_valid_i, ll_addr_i, ll_data_i,
    output issue_valid_i, issue_addr_i,
    output rs1_addr_i, rs2_addr_i,
    input  ll_ready_o, rs1_busy_o, rs2_busy_o, stall_o,
    input  RegWrite_o, RDaddr_o, RDdata_o
  );

  modport slave (
    input  wb_valid_i, wb_addr_i, wb_data_i,
    input  ll_valid_i, ll_addr_i, ll_data_i,
    input  issue_valid_i, issue_addr_i,
    input  rs1_addr_i, rs2_addr_i,
    output ll_ready_o, rs1_busy_o, rs2_busy_o, stall_o,
    output RegWrite_o, RDaddr_o, RDdata_o
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Owns the register file's single write port. In-order WB results normally
//   win the port; long-latency (LL) results are queued in a small FIFO and
//   written when WB is idle, or forcibly drained (stalling WB for one cycle)
//   once the FIFO head has lost to WB STARVE_MAX times. A pending-destination
//   scoreboard tells the hazard unit which registers still await an LL write.
//
//   Ports
//     clk_i  in  clock, rising edge
//     rst_i  in  asynchronous, active-low reset
//     bus    slave side of reg_write_arbiter_if (see interface header)
//
//   Parameters
//     DEPTH      LL FIFO entries (power of two, >= 2)
//     STARVE_MAX consecutive WB wins over a non-empty FIFO before a drain
module reg_write_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  reg_write_arbiter_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  // FIFO storage (no reset: contents are only meaningful under count_reg)
  logic [4:0]       fifo_addr_mem [DEPTH];
  logic [31:0]      fifo_data_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  logic [STV_W-1:0] starve_reg;
  logic [STV_W-1:0] starve_next;

  logic [31:0]      pending_reg;
  wire  [31:0]      pending_next;

  logic             reg_write_reg;
  logic [4:0]       rd_addr_reg;
  logic [31:0]      rd_data_reg;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             wb_go;
  logic             drain;
  logic [4:0]       head_addr;
  logic [31:0]      head_data;

  // ---------------------------------------------------------------------
  // Selection
  // ---------------------------------------------------------------------
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

  // ready depends only on the registered fill level, so a push is never
  // accepted into a full FIFO even when a pop happens on the same edge.
  assign bus.ll_ready_o = !full;
  // x0 results complete the handshake but are dropped.
  assign push  = bus.ll_valid_i && !full && (bus.ll_addr_i != 5'd0);

  assign wb_go = bus.wb_valid_i && (bus.wb_addr_i != 5'd0);
  assign drain = !empty && (starve_reg == STV_W'(STARVE_MAX));
  // Head is written on a forced drain, or whenever WB has nothing real to
  // write (including a WB aimed at x0).
  assign pop   = !empty && (drain || !wb_go);

  assign bus.stall_o = drain;

  assign head_addr = fifo_addr_mem[rd_ptr_reg];
  assign head_data = fifo_data_mem[rd_ptr_reg];

  always_comb begin
    starve_next = starve_reg;
    if (pop) begin
      starve_next = '0;
    end else if (wb_go && !empty && (starve_reg != STV_W'(STARVE_MAX))) begin
      starve_next = starve_reg + STV_W'(1);
    end
  end

  always_comb begin
    count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
  end

  // ---------------------------------------------------------------------
  // FIFO storage write
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr_mem[wr_ptr_reg] <= bus.ll_addr_i;
      fifo_data_mem[wr_ptr_reg] <= bus.ll_data_i;
    end
  end

  // ---------------------------------------------------------------------
  // Scoreboard: set on issue, clear when the popped head targets the bit.
  // A same-edge set overrides the clear so a re-issued destination stays
  // pending for its newer result.
  // ---------------------------------------------------------------------
  assign pending_next[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_sb
      logic set_bit;
      logic clr_bit;
      assign set_bit = bus.issue_valid_i && (bus.issue_addr_i == 5'(gi));
      assign clr_bit = pop && (head_addr == 5'(gi));
      assign pending_next[gi] = set_bit | (pending_reg[gi] & ~clr_bit);
    end
  endgenerate

  assign bus.rs1_busy_o = pending_reg[bus.rs1_addr_i];
  assign bus.rs2_busy_o = pending_reg[bus.rs2_addr_i];

  // ---------------------------------------------------------------------
  // State and registered write port
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      starve_reg    <= '0;
      pending_reg   <= '0;
      reg_write_reg <= 1'b0;
      rd_addr_reg   <= '0;
      rd_data_reg   <= '0;
    end else begin
      count_reg   <= count_next;
      starve_reg  <= starve_next;
      pending_reg <= pending_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end

      // Address/data only move on a real write; idle cycles just drop enable.
      reg_write_reg <= pop || wb_go;
      if (pop) begin
        rd_addr_reg <= head_addr;
        rd_data_reg <= head_data;
      end else if (wb_go) begin
        rd_addr_reg <= bus.wb_addr_i;
        rd_data_reg <= bus.wb_data_i;
      end
    end
  end

  assign bus.RegWrite_o = reg_write_reg;
  assign bus.RDaddr_o   = rd_addr_reg;
  assign bus.RDdata_o   = rd_data_reg;

endmodule
